// File: rtl/opsg_reg_ctrl.sv
// Host register controller for the OPSG sound generator: decodes SN76489-style
// latch/data bytes into tone/attenuation/noise registers and paces the host via READY.
module opsg_reg_ctrl #(
    parameter int WAIT_CYCLES = 32,
    parameter int CNT_WIDTH   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       ready,
    output logic       overrun,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] att0,
    output logic [3:0] att1,
    output logic [3:0] att2,
    output logic [3:0] att3,
    output logic [1:0] nf,
    output logic       fb,
    output logic       noise_rst
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ready_q;
    logic                 overrun_q;
    logic                 noise_rst_q;

    logic [9:0] tone_q [3];
    logic [9:0] tone_d [3];
    logic [3:0] att_q  [4];
    logic [3:0] att_d  [4];
    logic [1:0] nf_q, nf_d;
    logic       fb_q, fb_d;
    logic [1:0] lch_q, lch_d;
    logic       ltyp_q, ltyp_d;
    logic       noise_hit;
    logic       accept;
    logic [1:0] wch;
    logic       wtyp;

    assign accept = wr && ready_q;

    // A latch byte retargets the pointer and writes through it in the same cycle;
    // a data byte writes through the existing pointer.
    always_comb begin
        tone_d    = tone_q;
        att_d     = att_q;
        nf_d      = nf_q;
        fb_d      = fb_q;
        lch_d     = lch_q;
        ltyp_d    = ltyp_q;
        noise_hit = 1'b0;
        wch       = data[7] ? data[6:5] : lch_q;
        wtyp      = data[7] ? data[4]   : ltyp_q;
        if (accept) begin
            if (data[7]) begin
                lch_d  = data[6:5];
                ltyp_d = data[4];
            end
            if (wtyp) begin
                att_d[wch] = data[3:0];
            end else if (wch != 2'd3) begin
                if (data[7]) begin
                    tone_d[wch][3:0] = data[3:0];
                end else begin
                    tone_d[wch][9:4] = data[5:0];
                end
            end else begin
                fb_d      = data[2];
                nf_d      = data[1:0];
                noise_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) tone_q[i] <= '0;
            for (int i = 0; i < 4; i++) att_q[i] <= 4'hF;
            nf_q        <= '0;
            fb_q        <= 1'b0;
            lch_q       <= '0;
            ltyp_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            overrun_q   <= 1'b0;
            noise_rst_q <= 1'b0;
        end else begin
            tone_q      <= tone_d;
            att_q       <= att_d;
            nf_q        <= nf_d;
            fb_q        <= fb_d;
            lch_q       <= lch_d;
            ltyp_q      <= ltyp_d;
            noise_rst_q <= noise_hit;
            overrun_q   <= wr && !ready_q;
            case (state_q)
                IDLE: begin
                    if (accept && (WAIT_CYCLES > 0)) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_WIDTH'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Dropped writes do not touch the countdown.
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign overrun   = overrun_q;
    assign tone0     = tone_q[0];
    assign tone1     = tone_q[1];
    assign tone2     = tone_q[2];
    assign att0      = att_q[0];
    assign att1      = att_q[1];
    assign att2      = att_q[2];
    assign att3      = att_q[3];
    assign nf        = nf_q;
    assign fb        = fb_q;
    assign noise_rst = noise_rst_q;

endmodule

// File: doc/opsg_reg_ctrl.md
Name: opsg_reg_ctrl

Overview:
Host-side register controller for the OPSG sound generator. It accepts SN76489-style byte writes and decodes latch/data bytes into the three tone periods, four attenuations and the noise control. It drives the tone channels and the noise generator (nf, fb, freq), issues a one-cycle LFSR reseed pulse on every noise-register write, and paces the host with a READY/wait-state handshake.

Parameters:
WAIT_CYCLES, 32, cycles READY stays low after an accepted write (0 = READY never drops)
CNT_WIDTH, 6, width of the wait counter; must hold WAIT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
wr  input  1  write strobe, sampled high for one cycle per byte
data  input  8  host write byte
ready  output  1  1 = controller accepts a write this cycle
overrun  output  1  one-cycle pulse: write presented while ready=0 (write dropped)
tone0  output  10  channel 0 tone period
tone1  output  10  channel 1 tone period
tone2  output  10  channel 2 tone period; also noise freq source when nf=2'b11
att0  output  4  channel 0 attenuation
att1  output  4  channel 1 attenuation
att2  output  4  channel 2 attenuation
att3  output  4  noise channel attenuation
nf  output  2  noise rate select to noise generator
fb  output  1  noise feedback: 1 = white, 0 = periodic
noise_rst  output  1  one-cycle pulse: reseed noise LFSR

Behaviour:
- Reset (async, reset_n=0): tone0..2=0, att0..3=4'hF (silent), nf=0, fb=0, latch pointer = {ch0, tone}, state IDLE, ready=1, overrun=0, noise_rst=0, wait counter=0. Deassertion is sampled synchronously; the first write is accepted on the first rising edge with reset_n=1.
- Accept: the write is accepted on a rising edge with wr=1 and ready=1. Register updates are visible the following cycle (latency 1).
- Latch byte (data[7]=1): the latch pointer is set to channel=data[6:5] and type=data[4] (0 tone/noise, 1 atten).
  - type=1: att[ch] <= data[3:0].
  - type=0, ch0..2: tone[ch][3:0] <= data[3:0]; bits [9:4] are unchanged.
  - type=0, ch3: fb <= data[2], nf <= data[1:0], noise_rst pulses.
- Data byte (data[7]=0): applies to the current latch pointer, which is unchanged.
  - Tone ch0..2: tone[ch][9:4] <= data[5:0]; bits [3:0] are unchanged.
  - Atten: att[ch] <= data[3:0].
  - Noise: fb <= data[2], nf <= data[1:0], noise_rst pulses.
  - data[6] is ignored.
- noise_rst: high exactly one cycle, coincident with the new nf/fb values. It pulses even if the written value equals the old value.
- FSM:
  - IDLE: ready=1. An accepted write with WAIT_CYCLES>0 moves to BUSY and loads counter=WAIT_CYCLES.
  - BUSY: ready=0; counter decrements each cycle. On the cycle counter==1, return to IDLE (ready=1 next cycle).
  - Net effect: ready is low for exactly WAIT_CYCLES cycles after the accept edge.
  - WAIT_CYCLES=0: remain in IDLE; back-to-back writes are accepted every cycle.
- wr=1 while ready=0: the write is dropped, no register changes, overrun pulses the following cycle, and the BUSY countdown is not extended.
- wr held high across IDLE re-entry: accepted again on the first ready=1 cycle. Each ready=1 cycle with wr=1 is a new write.
- Reset mid-BUSY: immediately ready=1, all registers return to reset values, and any pending noise_rst pulse is cancelled.
- No arithmetic wrap: tone value 0 is stored as-is; its interpretation belongs to the tone and noise generators.

Test Plan:
- Reset, then observe: ready=1, att0..3=F, tone0..2=0, nf=0, fb=0, noise_rst=0.
- Write 8'h8E, wait for ready, then write 8'h0F -> tone0=10'h0FE. Ready is low for exactly 32 cycles after each accept.
- Write 8'hE5 -> fb=1, nf=2'b01, noise_rst high for exactly 1 cycle. Then write 8'h06 after ready -> fb=1, nf=2'b10, a second noise_rst pulse, latch pointer still noise.
- Write 8'hD3, then write 8'h07 while ready=0 -> att2=3, write dropped, overrun pulses once, ready returns 32 cycles after the first accept.
- With WAIT_CYCLES=0, send 8'hBA then 8'h05 on consecutive cycles -> att1=A then att1=5, ready constantly 1, overrun never asserts.
- Assert reset_n=0 mid-BUSY after 8'hC7 -> ready=1 and tone2=0 asynchronously. After release, 8'h9F is accepted on the first edge -> att0=F.
